// File: rtl/booth_radix4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, signed or
// unsigned per operation, optional early exit once the remaining digits are zero.
module booth_radix4_seq_mult #(
  parameter int WIDTH      = 8,
  parameter int EARLY_TERM = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  // extended multiplier (W+2 bits) plus the implicit b[-1] in bit 0
  localparam int BW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   acc, areg, product_r;
  logic [BW-1:0]   breg;
  logic [CW-1:0]   cnt;
  logic            sgn;

  logic [2:0]      triple;
  logic            single, double, neg;
  logic [PW-1:0]   mag, addend, acc_nxt;
  logic            last_digit, rest_zero, finish, accept;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC);
  assign out_valid = (state == DONE);
  assign product   = product_r;
  assign accept    = in_valid & in_ready;

  // Booth recode of the current triple; areg already carries the << 2i weight
  always_comb begin
    triple  = breg[2:0];
    single  = triple[0] ^ triple[1];
    double  = (triple == 3'b011) | (triple == 3'b100);
    neg     = triple[2];
    mag     = double ? (areg << 1) : (single ? areg : '0);
    addend  = neg ? (~mag + PW'(1)) : mag;
    acc_nxt = acc + addend;
  end

  always_comb begin
    last_digit = (cnt == (sgn ? LAST_S : LAST_U));
    // every bit from b[2i+1] upward matches b[2i+1] -> all later digits are zero
    rest_zero  = (breg[BW-1:2] == {(BW-2){breg[2]}});
    finish     = last_digit | ((EARLY_TERM != 0) & rest_zero);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (finish)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      areg      <= '0;
      breg      <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sgn  <= in_signed;
          acc  <= '0;
          cnt  <= '0;
          areg <= in_signed ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                            : {{WIDTH{1'b0}}, multiplicand};
          breg <= {(in_signed ? {2{multiplier[WIDTH-1]}} : 2'b00), multiplier, 1'b0};
        end
        CALC: begin
          acc  <= acc_nxt;
          areg <= areg << 2;
          breg <= {breg[BW-1], breg[BW-1], breg[BW-1:2]};
          cnt  <= cnt + CW'(1);
          if (finish) product_r <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
